// File: rtl/alu_fu_pkg.sv
// Shared RV32I encodings and the result record carried from the ALU pipeline
// through the output FIFO onto the CDB.
package alu_fu_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int TAG_W_DEF = 5;

    typedef enum logic [2:0] {
        OP_BRANCH = 3'd0,
        OP_ARITH  = 3'd1,
        OP_AUIPC  = 3'd2,
        OP_JAL    = 3'd3,
        OP_JALR   = 3'd4
    } op_t;

    typedef enum logic [2:0] {
        F3_ADD  = 3'b000,
        F3_SLL  = 3'b001,
        F3_SLT  = 3'b010,
        F3_SLTU = 3'b011,
        F3_XOR  = 3'b100,
        F3_SR   = 3'b101,
        F3_OR   = 3'b110,
        F3_AND  = 3'b111
    } arith_funct3_t;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } branch_funct3_t;

    typedef struct packed {
        logic [XLEN_DEF-1:0]  data;
        logic [TAG_W_DEF-1:0] tag;
        logic                 br_taken;
    } fu_result_t;

    // Ops whose result is a plain src1 + src2 (link address or PC-relative sum).
    function automatic logic is_link_sum(op_t op);
        return (op == OP_AUIPC) || (op == OP_JAL) || (op == OP_JALR);
    endfunction

endpackage

// File: rtl/alu_fu_fifo.sv
// Synchronous result FIFO with simultaneous push/pop (also at full), a
// synchronous flush, and an entry count; the head reads as zero when empty.
module alu_fu_fifo
    import alu_fu_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fu_result_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  entry_t                 push_data_i,
    input  logic                   pop_i,
    output entry_t                 head_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   rd_q;
    logic [AW-1:0]   wr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            empty;
    logic            full;
    logic            do_push;
    logic            do_pop;

    function automatic logic [AW-1:0] wrap_inc(logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty && !flush_i;
    assign do_push = push_i && !flush_i && (!full || do_pop);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: the storage array is deliberately not reset; validity is tracked by
    // the pointers and count alone, so resetting it would only add reset fanout.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wrap_inc(wr_q);
            if (do_pop)  rd_q <= wrap_inc(rd_q);
            count_q <= count_d;
        end
    end

    assign head_o  = empty ? '0 : mem_q[rd_q];
    assign count_o = count_q;

endmodule

// File: rtl/alu_fu.sv
// Pipelined RV32I integer ALU functional unit: decode/execute in stage 0,
// STAGES-1 further registers, then a credit-protected output FIFO to the CDB.
module alu_fu
    import alu_fu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int TAG_W     = 5,
    parameter int STAGES    = 1,
    parameter int OUT_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  op_t                        issue_op,
    input  logic                       issue_imm,
    input  logic [2:0]                 issue_funct3,
    input  logic                       issue_alt,
    input  logic [XLEN-1:0]            issue_src1,
    input  logic [XLEN-1:0]            issue_src2,
    input  logic [TAG_W-1:0]           issue_tag,
    output logic                       cdb_req,
    input  logic                       cdb_gnt,
    output logic [XLEN-1:0]            cdb_data,
    output logic [TAG_W-1:0]           cdb_tag,
    output logic                       cdb_br_taken,
    output logic [$clog2(OUT_DEPTH):0] occupancy
);

    localparam int OW = $clog2(OUT_DEPTH) + 1;
    localparam int SW = $clog2(XLEN);

    typedef struct packed {
        logic [XLEN-1:0]  data;
        logic [TAG_W-1:0] tag;
        logic             br_taken;
    } res_t;

    logic          fire;
    logic          pop;
    logic [OW-1:0] occ_q;
    logic [OW-1:0] occ_d;
    logic [SW-1:0] shamt;
    logic          eq;
    logic          lt_s;
    logic          lt_u;
    res_t          s0_res;
    res_t          push_res;
    logic          push_vld;
    res_t          head;
    logic [OW-1:0] fifo_count;

    // Occupancy counts in-flight plus buffered ops, so every accepted op owns
    // a FIFO slot and the execute pipeline never needs to stall.
    assign issue_ready = (occ_q < OW'(OUT_DEPTH)) && !flush;
    assign fire        = issue_valid && issue_ready;
    assign pop         = cdb_req && cdb_gnt && !flush;

    assign shamt = issue_src2[SW-1:0];
    assign eq    = (issue_src1 == issue_src2);
    assign lt_s  = $signed(issue_src1) < $signed(issue_src2);
    assign lt_u  = issue_src1 < issue_src2;

    // NOTE: every output of this block is defaulted first, so no path through
    // the case statements can leave a value held and infer a latch.
    always_comb begin
        s0_res     = '0;
        s0_res.tag = issue_tag;
        if (issue_op == OP_ARITH) begin
            case (arith_funct3_t'(issue_funct3))
                F3_ADD:  s0_res.data = (issue_alt && !issue_imm) ? issue_src1 - issue_src2
                                                                 : issue_src1 + issue_src2;
                F3_SLL:  s0_res.data = issue_src1 << shamt;
                F3_SLT:  s0_res.data = XLEN'(lt_s);
                F3_SLTU: s0_res.data = XLEN'(lt_u);
                F3_XOR:  s0_res.data = issue_src1 ^ issue_src2;
                F3_SR:   s0_res.data = issue_alt ? XLEN'($signed(issue_src1) >>> shamt)
                                                 : issue_src1 >> shamt;
                F3_OR:   s0_res.data = issue_src1 | issue_src2;
                F3_AND:  s0_res.data = issue_src1 & issue_src2;
                default: s0_res.data = '0;
            endcase
        end else if (issue_op == OP_BRANCH) begin
            case (branch_funct3_t'(issue_funct3))
                BR_BEQ:  s0_res.br_taken = eq;
                BR_BNE:  s0_res.br_taken = !eq;
                BR_BLT:  s0_res.br_taken = lt_s;
                BR_BGE:  s0_res.br_taken = !lt_s;
                BR_BLTU: s0_res.br_taken = lt_u;
                BR_BGEU: s0_res.br_taken = !lt_u;
                default: s0_res.br_taken = 1'b0;
            endcase
        end else if (is_link_sum(issue_op)) begin
            s0_res.data = issue_src1 + issue_src2;
        end
    end

    if (STAGES > 1) begin : g_pipe
        res_t [STAGES-2:0] res_q;
        logic [STAGES-2:0] vld_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                vld_q <= '0;
                res_q <= '0;
            end else if (flush) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= fire;
                res_q[0] <= s0_res;
                for (int i = 1; i < STAGES - 1; i++) begin
                    vld_q[i] <= vld_q[i-1];
                    res_q[i] <= res_q[i-1];
                end
            end
        end

        assign push_vld = vld_q[STAGES-2];
        assign push_res = res_q[STAGES-2];
    end else begin : g_direct
        // Single-stage unit: the FIFO entry itself is the stage-0 register.
        assign push_vld = fire;
        assign push_res = s0_res;
    end

    alu_fu_fifo #(
        .DEPTH   (OUT_DEPTH),
        .entry_t (res_t)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .push_i      (push_vld),
        .push_data_i (push_res),
        .pop_i       (cdb_gnt),
        .head_o      (head),
        .count_o     (fifo_count)
    );

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (fire && !pop) begin
            occ_d = occ_q + OW'(1);
        end else if (pop && !fire) begin
            occ_d = occ_q - OW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy    = occ_q;
    assign cdb_req      = (fifo_count != '0);
    assign cdb_data     = head.data;
    assign cdb_tag      = head.tag;
    assign cdb_br_taken = head.br_taken;

endmodule

// File: tb/tb_alu_fu.sv
// Bench for alu_fu: a STAGES=1 unit checked by a vector table plus scoreboard,
// and a STAGES=3 unit for pipeline flush and latency sequences.
module tb_alu_fu;
    import alu_fu_pkg::*;

    typedef struct {
        op_t         op;
        logic        imm;
        logic [2:0]  f3;
        logic        alt;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_data;
        logic        exp_br;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        logic        br;
    } exp_t;

    logic        clk;
    logic        rst;
    op_t         issue_op;
    logic        issue_imm;
    logic [2:0]  issue_funct3;
    logic        issue_alt;
    logic [31:0] issue_src1;
    logic [31:0] issue_src2;
    logic [4:0]  issue_tag;

    logic        flush, issue_valid, issue_ready, cdb_req, cdb_gnt, cdb_br_taken;
    logic [31:0] cdb_data;
    logic [4:0]  cdb_tag;
    logic [2:0]  occupancy;

    logic        d3_flush, d3_issue_valid, d3_issue_ready, d3_cdb_req, d3_cdb_gnt, d3_cdb_br_taken;
    logic [31:0] d3_cdb_data;
    logic [4:0]  d3_cdb_tag;
    logic [2:0]  d3_occupancy;

    int          n_vec;
    int          n_fail;
    logic        sb_en;
    logic [31:0] exp_data_cur;
    logic        exp_br_cur;
    exp_t        sb_q[$];
    exp_t        mon_e;
    vec_t        vecs[$];

    alu_fu #(.XLEN(32), .TAG_W(5), .STAGES(1), .OUT_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
        .issue_imm(issue_imm), .issue_funct3(issue_funct3), .issue_alt(issue_alt),
        .issue_src1(issue_src1), .issue_src2(issue_src2), .issue_tag(issue_tag),
        .cdb_req(cdb_req), .cdb_gnt(cdb_gnt), .cdb_data(cdb_data), .cdb_tag(cdb_tag),
        .cdb_br_taken(cdb_br_taken), .occupancy(occupancy)
    );

    alu_fu #(.XLEN(32), .TAG_W(5), .STAGES(3), .OUT_DEPTH(4)) dut3 (
        .clk(clk), .rst(rst), .flush(d3_flush),
        .issue_valid(d3_issue_valid), .issue_ready(d3_issue_ready), .issue_op(issue_op),
        .issue_imm(issue_imm), .issue_funct3(issue_funct3), .issue_alt(issue_alt),
        .issue_src1(issue_src1), .issue_src2(issue_src2), .issue_tag(issue_tag),
        .cdb_req(d3_cdb_req), .cdb_gnt(d3_cdb_gnt), .cdb_data(d3_cdb_data), .cdb_tag(d3_cdb_tag),
        .cdb_br_taken(d3_cdb_br_taken), .occupancy(d3_occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input op_t op, input logic imm, input logic [2:0] f3, input logic alt,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag,
                          input logic [31:0] ed, input logic eb);
        issue_op     = op;
        issue_imm    = imm;
        issue_funct3 = f3;
        issue_alt    = alt;
        issue_src1   = a;
        issue_src2   = b;
        issue_tag    = tag;
        exp_data_cur = ed;
        exp_br_cur   = eb;
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 20 && sb_q.size() != 0; k++) tick();
        check(name, 32'(sb_q.size()), 32'd0);
    endtask

    // Scoreboard: expectations enter on accept, leave when the CDB takes the head.
    always @(negedge clk) begin
        if (sb_en && rst && !flush) begin
            if (cdb_req && cdb_gnt) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_result", 32'(sb_q.size()), 32'd1);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("sb_data", cdb_data, mon_e.data);
                    check("sb_tag", 32'(cdb_tag), 32'(mon_e.tag));
                    check("sb_br_taken", 32'(cdb_br_taken), 32'(mon_e.br));
                end
            end
            if (issue_valid && issue_ready) begin
                sb_q.push_back('{data: exp_data_cur, tag: issue_tag, br: exp_br_cur});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        n_vec = 0;
        n_fail = 0;
        sb_en = 1'b0;
        rst = 1'b0;
        flush = 1'b0;
        issue_valid = 1'b0;
        cdb_gnt = 1'b0;
        d3_flush = 1'b0;
        d3_issue_valid = 1'b0;
        d3_cdb_gnt = 1'b0;
        set_op(OP_ARITH, 1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);

        vecs.push_back('{OP_ARITH,  1'b0, 3'b000, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0});
        vecs.push_back('{OP_ARITH,  1'b1, 3'b000, 1'b1, 32'h00000005, 32'h00000003, 32'h00000008, 1'b0});
        vecs.push_back('{OP_ARITH,  1'b0, 3'b000, 1'b1, 32'h00000005, 32'h00000003, 32'h00000002, 1'b0});
        vecs.push_back('{OP_ARITH,  1'b0, 3'b101, 1'b1, 32'h80000000, 32'h00000024, 32'hF8000000, 1'b0});
        vecs.push_back('{OP_ARITH,  1'b0, 3'b101, 1'b0, 32'h80000000, 32'h00000024, 32'h08000000, 1'b0});
        vecs.push_back('{OP_ARITH,  1'b0, 3'b010, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0});
        vecs.push_back('{OP_ARITH,  1'b0, 3'b011, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0});
        vecs.push_back('{OP_ARITH,  1'b1, 3'b001, 1'b0, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 1'b0});
        vecs.push_back('{OP_ARITH,  1'b0, 3'b100, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0});
        vecs.push_back('{OP_ARITH,  1'b0, 3'b110, 1'b0, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0});
        vecs.push_back('{OP_ARITH,  1'b0, 3'b111, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0});
        vecs.push_back('{OP_AUIPC,  1'b0, 3'b000, 1'b0, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 1'b0});
        vecs.push_back('{OP_JAL,    1'b0, 3'b000, 1'b0, 32'h00001000, 32'h00000004, 32'h00001004, 1'b0});
        vecs.push_back('{OP_JALR,   1'b0, 3'b000, 1'b0, 32'h00002000, 32'hFFFFFFFC, 32'h00001FFC, 1'b0});
        vecs.push_back('{OP_BRANCH, 1'b0, 3'b100, 1'b0, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1});
        vecs.push_back('{OP_BRANCH, 1'b0, 3'b111, 1'b0, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1});
        vecs.push_back('{OP_BRANCH, 1'b0, 3'b000, 1'b0, 32'h00000005, 32'h00000006, 32'h00000000, 1'b0});
        vecs.push_back('{OP_BRANCH, 1'b0, 3'b001, 1'b0, 32'h00000005, 32'h00000006, 32'h00000000, 1'b1});
        vecs.push_back('{OP_BRANCH, 1'b0, 3'b101, 1'b0, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0});
        vecs.push_back('{OP_BRANCH, 1'b0, 3'b110, 1'b0, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0});
        vecs.push_back('{OP_BRANCH, 1'b0, 3'b010, 1'b0, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0});
        vecs.push_back('{op_t'(3'd7), 1'b0, 3'b000, 1'b0, 32'h12345678, 32'h11111111, 32'h00000000, 1'b0});

        // Reset state, observed while reset is still asserted.
        #2;
        check("rst_cdb_req", 32'(cdb_req), 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_cdb_data", cdb_data, 32'd0);
        check("rst_cdb_tag", 32'(cdb_tag), 32'd0);
        check("rst_cdb_br_taken", 32'(cdb_br_taken), 32'd0);
        check("rst_d3_occupancy", 32'(d3_occupancy), 32'd0);
        #20;
        rst = 1'b1;
        tick();
        check("rst_issue_ready", 32'(issue_ready), 32'd1);

        // One-cycle latency with the grant held off, then a single pop.
        set_op(OP_ARITH, 1'b0, 3'b000, 1'b0, 32'h7FFFFFFF, 32'h1, 5'd3, 32'h80000000, 1'b0);
        issue_valid = 1'b1;
        check("lat_req_before", 32'(cdb_req), 32'd0);
        tick();
        issue_valid = 1'b0;
        check("lat_req", 32'(cdb_req), 32'd1);
        check("lat_data", cdb_data, 32'h80000000);
        check("lat_tag", 32'(cdb_tag), 32'd3);
        check("lat_occupancy", 32'(occupancy), 32'd1);
        cdb_gnt = 1'b1;
        tick();
        check("lat_req_after_pop", 32'(cdb_req), 32'd0);
        check("lat_occ_after_pop", 32'(occupancy), 32'd0);

        // Vector table, one issue per cycle with the CDB always granting.
        sb_en = 1'b1;
        foreach (vecs[i]) begin
            set_op(vecs[i].op, vecs[i].imm, vecs[i].f3, vecs[i].alt, vecs[i].a, vecs[i].b,
                   5'(i), vecs[i].exp_data, vecs[i].exp_br);
            issue_valid = 1'b1;
            tick();
        end
        issue_valid = 1'b0;
        wait_drain("table_drain");

        // Backpressure: with no grant only OUT_DEPTH ops are accepted.
        cdb_gnt = 1'b0;
        accepted = 0;
        for (int i = 0; i < 8; i++) begin
            set_op(OP_ARITH, 1'b0, 3'b000, 1'b0, 32'(i), 32'd100, 5'(i + 10), 32'(i + 100), 1'b0);
            issue_valid = 1'b1;
            if (issue_ready) accepted++;
            tick();
        end
        issue_valid = 1'b0;
        check("bp_accepted", 32'(accepted), 32'd4);
        check("bp_ready_full", 32'(issue_ready), 32'd0);
        check("bp_occupancy_full", 32'(occupancy), 32'd4);
        cdb_gnt = 1'b1;
        #1;
        check("bp_ready_before_pop", 32'(issue_ready), 32'd0);
        tick();
        check("bp_ready_after_pop", 32'(issue_ready), 32'd1);
        check("bp_occupancy_3", 32'(occupancy), 32'd3);
        tick();
        check("bp_occupancy_2", 32'(occupancy), 32'd2);
        wait_drain("bp_drain");
        tick();
        tick();
        check("gnt_empty_occupancy", 32'(occupancy), 32'd0);
        check("gnt_empty_req", 32'(cdb_req), 32'd0);

        // Flush with a grant and an issue attempt in the same cycle.
        cdb_gnt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_op(OP_JAL, 1'b0, 3'b000, 1'b0, 32'h40, 32'(i), 5'(20 + i), 32'(32'h40 + i), 1'b0);
            issue_valid = 1'b1;
            tick();
        end
        set_op(OP_ARITH, 1'b0, 3'b000, 1'b0, 32'h1, 32'h1, 5'd22, 32'h2, 1'b0);
        flush = 1'b1;
        cdb_gnt = 1'b1;
        #1;
        check("flush_ready", 32'(issue_ready), 32'd0);
        tick();
        flush = 1'b0;
        issue_valid = 1'b0;
        sb_q.delete();
        check("flush_req", 32'(cdb_req), 32'd0);
        check("flush_occupancy", 32'(occupancy), 32'd0);
        set_op(OP_ARITH, 1'b0, 3'b111, 1'b0, 32'hFFFF0000, 32'h0F0F0F0F, 5'd23, 32'h0F0F0000, 1'b0);
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        wait_drain("post_flush_drain");

        // STAGES=3: ops in flight are killed by a flush before reaching the FIFO.
        d3_cdb_gnt = 1'b0;
        set_op(OP_ARITH, 1'b0, 3'b000, 1'b0, 32'h10, 32'h1, 5'd1, 32'h11, 1'b0);
        d3_issue_valid = 1'b1;
        tick();
        set_op(OP_ARITH, 1'b0, 3'b000, 1'b0, 32'h20, 32'h1, 5'd2, 32'h21, 1'b0);
        tick();
        set_op(OP_ARITH, 1'b0, 3'b000, 1'b0, 32'h30, 32'h1, 5'd3, 32'h31, 1'b0);
        d3_flush = 1'b1;
        #1;
        check("d3_occ_before_flush", 32'(d3_occupancy), 32'd2);
        check("d3_ready_in_flush", 32'(d3_issue_ready), 32'd0);
        tick();
        d3_flush = 1'b0;
        d3_issue_valid = 1'b0;
        check("d3_occ_after_flush", 32'(d3_occupancy), 32'd0);
        for (int k = 0; k < 5; k++) begin
            check("d3_no_req_after_flush", 32'(d3_cdb_req), 32'd0);
            tick();
        end
        set_op(OP_ARITH, 1'b0, 3'b000, 1'b0, 32'h1, 32'h2, 5'd9, 32'h3, 1'b0);
        d3_issue_valid = 1'b1;
        tick();
        d3_issue_valid = 1'b0;
        check("d3_req_stage1", 32'(d3_cdb_req), 32'd0);
        tick();
        check("d3_req_stage2", 32'(d3_cdb_req), 32'd0);
        tick();
        check("d3_req_stage3", 32'(d3_cdb_req), 32'd1);
        check("d3_data", d3_cdb_data, 32'h3);
        check("d3_tag", 32'(d3_cdb_tag), 32'd9);
        check("d3_br_taken", 32'(d3_cdb_br_taken), 32'd0);
        check("d3_occupancy_1", 32'(d3_occupancy), 32'd1);
        d3_cdb_gnt = 1'b1;
        tick();
        d3_cdb_gnt = 1'b0;
        check("d3_req_popped", 32'(d3_cdb_req), 32'd0);
        check("d3_occupancy_0", 32'(d3_occupancy), 32'd0);

        // Asynchronous reset between edges with two results buffered.
        sb_en = 1'b0;
        cdb_gnt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_op(OP_AUIPC, 1'b0, 3'b000, 1'b0, 32'h100, 32'(i), 5'(30 + i), 32'(32'h100 + i), 1'b0);
            issue_valid = 1'b1;
            tick();
        end
        issue_valid = 1'b0;
        check("arst_occ_before", 32'(occupancy), 32'd2);
        check("arst_req_before", 32'(cdb_req), 32'd1);
        #3;
        rst = 1'b0;
        #1;
        check("arst_req", 32'(cdb_req), 32'd0);
        check("arst_occupancy", 32'(occupancy), 32'd0);
        check("arst_data", cdb_data, 32'd0);
        #1;
        rst = 1'b1;
        #1;
        check("arst_ready_release", 32'(issue_ready), 32'd1);
        sb_q.delete();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_fu.md
Name: alu_fu

Overview:
- Parametrised, pipelined integer ALU functional unit for the Tomasulo core.
- Accepts one operation per cycle from the ALU reservation station over a valid/ready handshake and computes RV32I arithmetic, shift, compare, branch-condition and link/AUIPC sums.
- Carries the ROB tag down a STAGES-deep pipeline into an output FIFO, which arbitrates onto the CDB with a request/grant handshake.
- Supports flush on mispredict and never drops a completed result under CDB backpressure.

Parameters:
- XLEN, 32, operand/result width.
- TAG_W, 5, ROB tag width.
- STAGES, 1, execute pipeline depth (1..4); result appears at FIFO input STAGES cycles after issue.
- OUT_DEPTH, 4, output FIFO entries (power of 2, >= STAGES).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  kill all in-flight and buffered ops (mispredict).
- issue_valid  in  1  RS presents an op.
- issue_ready  out  1  FU can accept an op this cycle.
- issue_op  in  op_t  BRANCH/ARITH/AUIPC/JAL/JALR.
- issue_imm  in  1  op is register-immediate (suppresses SUB).
- issue_funct3  in  3  RV32I funct3.
- issue_alt  in  1  funct7[5] (SUB/SRA select).
- issue_src1  in  XLEN  operand A.
- issue_src2  in  XLEN  operand B.
- issue_tag  in  TAG_W  destination ROB tag.
- cdb_req  out  1  head result pending.
- cdb_gnt  in  1  CDB arbiter accepts head this cycle.
- cdb_data  out  XLEN  head result.
- cdb_tag  out  TAG_W  head tag.
- cdb_br_taken  out  1  head branch condition (0 for non-branch).
- occupancy  out  $clog2(OUT_DEPTH)+1  in-flight plus buffered entries.

Behaviour:
- Reset (rst low, asynchronous): all pipeline valid bits 0, FIFO empty, occupancy 0, cdb_req 0, cdb_data/cdb_tag/cdb_br_taken 0, issue_ready 1 after release.
- Accept: fire = issue_valid && issue_ready.
  - issue_ready = (occupancy < OUT_DEPTH) && !flush.
  - Credit scheme guarantees a FIFO slot for every in-flight op, so the pipeline never stalls.
- Op decode, combinational in stage 0:
  - ARITH funct3 000: SUB if issue_alt && !issue_imm, else ADD.
  - ARITH 001 SLL; 010 SLT (signed, result zero-extended 0/1); 011 SLTU; 100 XOR; 101 SRA if issue_alt, else SRL; 110 OR; 111 AND.
  - Shift amount is src2[4:0] (log2 XLEN bits).
  - AUIPC/JAL/JALR: data = src1 + src2, wrapping modulo 2^XLEN.
  - BRANCH: data = 0; br_taken = BEQ/BNE/BLT/BGE/BLTU/BGEU per funct3. funct3 010/011 → br_taken 0.
  - Unknown op: data 0, br_taken 0, still retires its tag (no X propagation).
- Pipeline: stage 0 result registered, then shifted through STAGES-1 further registers with tag and valid. Issue at cycle t → FIFO write at edge t+STAGES → cdb_req visible from cycle t+STAGES if FIFO was empty.
- FIFO: head drives cdb_*; cdb_req = !empty.
  - Pop on cdb_req && cdb_gnt.
  - Push and pop in the same cycle allowed, including at full.
  - Pointers wrap modulo OUT_DEPTH.
  - cdb_gnt while empty is ignored.
- occupancy: +1 on fire, -1 on pop, unchanged when both occur.
- Flush (synchronous, sampled at clk edge):
  - Clears all pipeline valids and the FIFO; occupancy becomes 0.
  - A grant in the same cycle is ignored (head discarded); no issue accepted that cycle.
  - cdb_req low the cycle after flush.
- Reset asserted mid-operation discards everything immediately, regardless of clk.

Decomposition:
- rv32i_types: op_t, alu_ops, branch_funct3_t, arith_funct3_t.
- Add to shared package: fu_result_t {data, tag, br_taken}.
- Sub-module: alu_fu_fifo (parametrised sync FIFO of fu_result_t, simultaneous push/pop, count output).
- Combinational datapath stays inline.

Test Plan:
- STAGES=1, issue ARITH add src1=0x7FFFFFFF src2=1 tag=3, gnt held 1 → cdb_req at cycle+1 with data 0x80000000, tag 3; SUB imm=1 alt=1 5,3 → 8 (ADD).
- SRA alt=1 src1=0x80000000 src2=0x24 → 0xF8000000 (shamt 4); SRL same → 0x08000000; SLT -1,1 → 1; SLTU -1,1 → 0.
- BRANCH BLT src1=0xFFFFFFFF src2=0 → br_taken 1, data 0; BGEU same operands → br_taken 1; BEQ 5,6 → 0.
- OUT_DEPTH=4, gnt=0, issue every cycle → exactly 4 accepted, issue_ready 0, occupancy 4. Raise gnt → results drain in issue order, one per cycle, ready reasserts the cycle after the first pop.
- STAGES=3, issue 3 ops, assert flush the cycle after the second → no cdb_req ever for any of them, occupancy 0, next issue completes normally 3 cycles later.
- Assert rst low asynchronously between edges with FIFO holding 2 → cdb_req and occupancy drop to 0 immediately; release → issue_ready 1.
